// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ producers.
// Grants one byte, waits for frame done or watchdog, then holds an idle gap.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int LOG2_N_REQ     = 2,
  parameter int NB_DATA        = 8,
  parameter int NB_CNT         = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_grant,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic                     o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  localparam logic [NB_CNT-1:0] TO_LAST =
    NB_CNT'(TIMEOUT_CYCLES - 1);
  localparam logic [NB_CNT-1:0] GAP_LAST =
    NB_CNT'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LOG2_N_REQ:0] N_W =
    (LOG2_N_REQ+1)'(N_REQ);

  state_t                  state, state_n;
  logic [LOG2_N_REQ-1:0]   ptr, ptr_n;
  logic [NB_CNT-1:0]       cnt, cnt_n;
  logic [N_REQ-1:0]        grant_n;
  logic [NB_DATA-1:0]      data_n;
  logic                    start_n;
  logic                    busy_n;
  logic                    to_n;

  logic [LOG2_N_REQ-1:0]   win;
  logic [LOG2_N_REQ-1:0]   idx;
  logic [LOG2_N_REQ:0]     sum;
  logic                    found;

  // First pending request at or above ptr, wrapping past N_REQ-1.
  always_comb begin
    win   = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (LOG2_N_REQ+1)'(i);
      if (sum >= N_W)
        sum = sum - N_W;
      idx = sum[LOG2_N_REQ-1:0];
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = '0;
    start_n = 1'b0;
    data_n  = o_tx_data;
    to_n    = o_timeout;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = N_REQ'(1) << win;
          start_n = 1'b1;
          data_n  = i_data[win*NB_DATA +: NB_DATA];
          ptr_n   = (win == LOG2_N_REQ'(N_REQ - 1)) ?
                    '0 : win + LOG2_N_REQ'(1);
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        cnt_n = cnt + NB_CNT'(1);
        // A done pulse coinciding with expiry is a clean frame.
        if (i_tx_done || cnt == TO_LAST) begin
          if (!i_tx_done)
            to_n = 1'b1;
          cnt_n   = '0;
          state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        cnt_n = cnt + NB_CNT'(1);
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      o_grant    <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      o_grant    <= grant_n;
      o_tx_start <= start_n;
      o_tx_data  <= data_n;
      o_busy     <= busy_n;
      o_timeout  <= to_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table on a gapless short-watchdog
// instance, directed sequences and a random run on a gapped instance.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [3:0]  req_a = '0, req_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        done_a = 1'b0, done_b = 1'b0;
  logic [3:0]  grant_a, grant_b;
  logic [7:0]  txd_a, txd_b;
  logic        start_a, start_b, busy_a, busy_b, to_a, to_b;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.GAP_CYCLES(16), .TIMEOUT_CYCLES(64)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_req(req_a), .i_data(data_a),
    .o_grant(grant_a), .o_tx_data(txd_a), .o_tx_start(start_a),
    .i_tx_done(done_a), .o_busy(busy_a), .o_timeout(to_a)
  );

  uart_tx_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_req(req_b), .i_data(data_b),
    .o_grant(grant_b), .o_tx_data(txd_b), .o_tx_start(start_b),
    .i_tx_done(done_b), .o_busy(busy_b), .o_timeout(to_b)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic       s;
    logic [7:0] d;
    logic       b;
    logic       t;
  } vec_t;

  vec_t tbl[23];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic dn,
                              input logic [3:0] g, input logic s,
                              input logic [7:0] d, input logic b,
                              input logic t);
    vec_t v;
    v.req = r; v.done = dn; v.g = g; v.s = s;
    v.d = d; v.b = b; v.t = t;
    return v;
  endfunction

  function automatic int first_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  // Reference model: frame / watchdog / gap tracked as remaining-time
  logic [3:0] e_grant;
  logic       e_start, e_busy, e_to;
  logic [7:0] e_data;
  bit         m_frame;
  int         m_wd, m_gap, m_ptr;

  task automatic model_reset();
    e_grant = '0; e_start = 0; e_busy = 0; e_to = 0; e_data = '0;
    m_frame = 0; m_wd = 0; m_gap = 0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] d,
                            input logic dn);
    int w;
    e_grant = '0;
    e_start = 0;
    if (m_frame) begin
      if (dn) begin
        m_frame = 0; m_gap = 16;
      end else begin
        m_wd--;
        if (m_wd == 0) begin
          e_to = 1; m_frame = 0; m_gap = 16;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != 0) begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (w < 0 && r[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      e_grant = 4'(1 << w);
      e_start = 1;
      e_data  = d[w*8 +: 8];
      m_ptr   = (w + 1) % 4;
      m_frame = 1;
      m_wd    = 64;
    end
    e_busy = m_frame || (m_gap > 0);
  endtask

  int         got, prev, n;
  int         order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] pend;
  logic [7:0] bytes[4];

  initial begin
    tbl[0] = mk(4'h0, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[1] = mk(4'h0, 1, 4'h0, 0, 8'h00, 0, 0);
    tbl[2] = mk(4'h2, 0, 4'h2, 1, 8'h22, 1, 0);
    for (int i = 3; i <= 9; i++)
      tbl[i] = mk(4'h0, 0, 4'h0, 0, 8'h22, 1, 0);
    tbl[10] = mk(4'h0, 1, 4'h0, 0, 8'h22, 0, 0);
    tbl[11] = mk(4'h3, 0, 4'h1, 1, 8'h11, 1, 0);
    for (int i = 12; i <= 18; i++)
      tbl[i] = mk(4'h0, 0, 4'h0, 0, 8'h11, 1, 0);
    tbl[19] = mk(4'h0, 0, 4'h0, 0, 8'h11, 0, 1);
    tbl[20] = mk(4'h3, 0, 4'h2, 1, 8'h22, 1, 1);
    tbl[21] = mk(4'h0, 1, 4'h0, 0, 8'h22, 0, 1);
    tbl[22] = mk(4'h4, 0, 4'h4, 1, 8'h33, 1, 1);

    data_b = 32'h44332211;
    repeat (2) tick();
    rst = 1'b0;
    chk("a_reset", {17'd0, grant_a, start_a, txd_a, busy_a, to_a}, 0);

    for (int i = 0; i < 23; i++) begin
      req_b  = tbl[i].req;
      done_b = tbl[i].done;
      tick();
      chk($sformatf("vec%0d", i),
          {17'd0, grant_b, start_b, txd_b, busy_b, to_b},
          {17'd0, tbl[i].g, tbl[i].s, tbl[i].d, tbl[i].b, tbl[i].t});
    end
    req_b = '0; done_b = 0;

    // Fairness with all four requesting
    req_a  = 4'hF;
    data_a = 32'h44332211;
    prev   = -1;
    for (int g = 0; g < 5; g++) begin
      got = -1;
      for (int c = 0; c < 60 && got < 0; c++) begin
        tick();
        if (grant_a != 0) begin
          got = first_idx(grant_a);
          chk("rr_onehot", $countones(grant_a), 1);
        end
      end
      chk("rr_order", got, order[g]);
      chk("rr_repeat", (got == prev) ? 1 : 0, 0);
      prev = got;
      if (got >= 0) req_a[got] = 1'b0;
      repeat (3) tick();
      done_a = 1; tick(); done_a = 0;
      tick();
      if (got >= 0) req_a[got] = 1'b1;
    end
    req_a = '0;
    repeat (20) tick();

    // Single request, then 16-cycle gap
    data_a = 32'h44A52211;
    req_a  = 4'b0100;
    tick();
    chk("single", {grant_a, start_a, txd_a, busy_a}, {4'b0100, 1'b1, 8'hA5, 1'b1});
    req_a = '0;
    repeat (19) tick();
    chk("single_busy", {start_a, busy_a}, 2'b01);
    done_a = 1; tick(); done_a = 0;
    chk("gap_entry", busy_a, 1);
    n = 0;
    while (busy_a && n < 40) begin
      tick();
      n++;
    end
    chk("gap_len", n, 16);

    // ptr is now 3: wrap to requester 0, then ptr 1
    req_a = 4'b0011;
    tick();
    chk("wrap", {grant_a, txd_a}, {4'b0001, 8'h11});
    req_a = '0;
    repeat (3) tick();
    done_a = 1; tick(); done_a = 0;
    repeat (18) tick();
    chk("wrap_idle", busy_a, 0);
    req_a = 4'b0011;
    tick();
    chk("wrap_next", grant_a, 4'b0010);
    req_a = '0;

    // Reset mid-frame, pointer must restart at 0
    repeat (3) tick();
    chk("pre_rst_busy", busy_a, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_outs", {17'd0, grant_a, start_a, txd_a, busy_a, to_a}, 0);
    req_a = 4'b1010;
    tick();
    chk("rst_ptr", grant_a, 4'b0010);
    req_a = '0;

    // Random traffic against the model
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    pend = '0;
    for (int k = 0; k < 4; k++) bytes[k] = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rand", {17'd0, grant_a, start_a, txd_a, busy_a, to_a},
          {17'd0, e_grant, e_start, e_data, e_busy, e_to});
      for (int k = 0; k < 4; k++) begin
        if (e_grant[k])
          pend[k] = 1'b0;
        else if (!pend[k] && $urandom_range(7) == 0) begin
          pend[k]  = 1'b1;
          bytes[k] = 8'($urandom);
        end
      end
      req_a = pend;
      for (int k = 0; k < 4; k++) data_a[k*8 +: 8] = bytes[k];
      done_a = m_frame ? ($urandom_range(15) == 0)
                       : ($urandom_range(31) == 0);
      model_step(req_a, data_a, done_a);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte producers. It samples pending requests, captures the winning byte and issues a one-cycle start to the transmitter. It then holds off further grants until the transmitter reports frame completion or a watchdog expires, and enforces an optional inter-frame gap. It sits between the producer blocks and the `i_data`/`i_tx_start` side of the UART transmitter.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `LOG2_N_REQ`, 2: clog2(`N_REQ`), width of the priority pointer.
- `NB_DATA`, 8: byte width.
- `NB_CNT`, 16: width of the shared timeout/gap counter.
- `TIMEOUT_CYCLES`, 4096: maximum cycles in BUSY before abort (1..2^`NB_CNT`-1).
- `GAP_CYCLES`, 16: idle cycles after each frame (0..2^`NB_CNT`-1; 0 = no gap).

Ports:
- `i_clock`, in, 1: single clock.
- `i_reset`, in, 1: synchronous reset, active-high.
- `i_req`, in, `N_REQ`: request bit k; held high with its data stable until `o_grant[k]` is seen.
- `i_data`, in, `N_REQ*NB_DATA`: requester k's byte occupies bits [k*NB_DATA +: NB_DATA].
- `o_grant`, out, `N_REQ`: one-hot, one-cycle pulse; byte k captured.
- `o_tx_data`, out, `NB_DATA`: byte presented to the transmitter, stable from the start pulse until the next grant.
- `o_tx_start`, out, 1: one-cycle pulse to the transmitter.
- `i_tx_done`, in, 1: one-cycle pulse from the transmitter at end of frame.
- `o_busy`, out, 1: high whenever state ≠ IDLE.
- `o_timeout`, out, 1: sticky watchdog error flag, cleared only by reset.

## Operation
- States: IDLE, BUSY, GAP. All outputs are registered.
- IDLE:
  - If `|i_req` is true, pick the winner w = the first set bit searching from `ptr` upward with wrap-around.
  - At that edge: `o_tx_data`←byte w, `o_grant`←onehot(w), `o_tx_start`←1, `ptr`←(w+1) mod `N_REQ`, counter←0, state←BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - The counter increments every cycle.
  - If `i_tx_done` is high, go to GAP (counter←0), or to IDLE if `GAP_CYCLES`=0.
  - Else, if counter = `TIMEOUT_CYCLES`-1, set `o_timeout`←1 and take the same exit as `i_tx_done`.
  - `i_req` is ignored in this state.
- GAP:
  - The counter increments every cycle.
  - When counter = `GAP_CYCLES`-1, go to IDLE.
  - `i_req` and `i_tx_done` are ignored.
- `i_tx_done` in IDLE or GAP has no effect.
- `o_grant` and `o_tx_start` are forced to 0 on every cycle except the grant edge.
- Priority pointer:
  - Reset value is 0.
  - It changes only on a grant.
  - A requester that keeps `i_req` high cannot starve others: after a grant it becomes lowest priority.
- Counter arithmetic is unsigned `NB_CNT` bits. The counter never wraps because the exits occur before overflow.
- Reset, including mid-frame: state←IDLE, `ptr`←0, counter←0, `o_grant`←0, `o_tx_start`←0, `o_tx_data`←0, `o_busy`←0, `o_timeout`←0. A frame already in flight in the transmitter is not tracked after reset.

## Timing
- Grant latency: `i_req` high at edge n gives `o_grant`, `o_tx_start` and the new `o_tx_data` high/valid in cycle n+1. `o_busy` is high from n+1.
- The requester drops `i_req` in the cycle after seeing `o_grant`. The arbiter does not sample `i_req` again until it re-enters IDLE, which takes at least 2 cycles.
- `i_tx_done` sampled at edge m: state is GAP from m+1 and IDLE from m+1+`GAP_CYCLES`. The earliest next grant is at m+2+`GAP_CYCLES`.
- Timeout: with no done pulse, `o_timeout` rises exactly `TIMEOUT_CYCLES` cycles after `o_tx_start`.
- If `i_tx_done` and timeout expiry coincide, done wins: `o_timeout` is unchanged.
- Throughput: one byte per (frame length + `GAP_CYCLES` + 1) cycles.

## Test plan
- Single request: `i_req`=4'b0100, byte2=8'hA5 → next cycle `o_grant`=4'b0100, `o_tx_start`=1, `o_tx_data`=8'hA5, `o_busy`=1; done pulse 20 cycles later → `o_busy` falls 16 cycles after GAP entry.
- Round-robin fairness: `i_req`=4'b1111 held continuously, each requester dropping only after its own grant and re-raising during GAP → grant order 0,1,2,3,0; no requester granted twice in a row.
- Wrap-around: ptr=3 with `i_req`=4'b0011 → grant goes to 0, then ptr=1.
- Timeout: `TIMEOUT_CYCLES`=8, no `i_tx_done` → `o_timeout`=1 exactly 8 cycles after `o_tx_start`, FSM returns to IDLE and then grants normally; `o_timeout` stays 1. `i_tx_done` coincident with expiry → `o_timeout` stays 0.
- `GAP_CYCLES`=0 and spurious `i_tx_done` in IDLE: done at edge m → IDLE at m+1, grant possible at m+2; spurious done causes no state change.
- Reset mid-BUSY → all outputs 0 the next cycle, ptr=0; a subsequent `i_req`=4'b1010 grants requester 1 first.
